// File: rtl/max_pool_reducer.sv
// max_pool_reducer: reduces each window of WINDOW IEEE-754 single-precision
// samples to its maximum and the position of that maximum within the window.
// The result is held under valid/ready handshake until downstream takes it.
module max_pool_reducer #(
    parameter int WINDOW    = 4,
    parameter int IDX_WIDTH = 2,
    localparam int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_index
);

    // Counter must be able to hold the value WINDOW itself.
    localparam int CNT_W = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic [IDX_WIDTH-1:0]  res_idx_q, res_idx_d;
    logic                  take;

    // Strict a > b under sign-magnitude ordering. +0 and -0 are equal; all
    // other patterns (denormals, Inf, NaN) are ordered purely by their bits.
    function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
        logic a_zero;
        logic b_zero;
        logic result;
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        if (a_zero && b_zero) begin
            result = 1'b0;
        end else if (a[31] != b[31]) begin
            // Differing signs: a wins exactly when b is the negative one.
            result = b[31];
        end else if (a[31] == 1'b0) begin
            result = (a[30:0] > b[30:0]);
        end else begin
            result = (a[30:0] < b[30:0]);
        end
        return result;
    endfunction

    // The result registers are separate from the running max so out_data
    // only changes when a window completes, not while one accumulates.
    assign in_ready  = (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = res_data_q;
    assign out_index = res_idx_q;

    assign take = in_valid && (state_q != S_DONE);

    // Next-state, running-max update and result capture.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        max_d      = max_q;
        idx_d      = idx_q;
        res_data_d = res_data_q;
        res_idx_d  = res_idx_q;
        case (state_q)
            S_EMPTY: begin
                if (take) begin
                    max_d   = in_data;
                    idx_d   = '0;
                    count_d = CNT_W'(1);
                    if (WINDOW == 1) begin
                        res_data_d = in_data;
                        res_idx_d  = '0;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (take) begin
                    // Ties keep the earlier sample: replace only on strictly greater.
                    if (fp_gt(in_data, max_q)) begin
                        max_d = in_data;
                        idx_d = IDX_WIDTH'(count_q);
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_d == CNT_W'(WINDOW)) begin
                        res_data_d = max_d;
                        res_idx_d  = idx_d;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    count_d = '0;
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial window or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            count_q    <= '0;
            max_q      <= '0;
            idx_q      <= '0;
            res_data_q <= '0;
            res_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            max_q      <= max_d;
            idx_q      <= idx_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
        end
    end

endmodule

// File: doc/max_pool_reducer.md
MAX_POOL_REDUCER -- requirements
Module: max_pool_reducer

Interface
REQ-001 The block SHALL have parameter WINDOW, default 4, meaning the number of input samples reduced to one maximum (legal range 2..256).
REQ-002 The block SHALL have parameter IDX_WIDTH, default 2, meaning the width of the argmax index (legal if 2**IDX_WIDTH >= WINDOW).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  input sample present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts the input sample this cycle.
REQ-007 The block SHALL have port in_data  input  `DATA_WIDTH  IEEE-754 single-precision sample.
REQ-008 The block SHALL have port out_valid  output  1  window maximum available.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-010 The block SHALL have port out_data  output  `DATA_WIDTH  maximum of the window, bit-exact copy of the winning input.
REQ-011 The block SHALL have port out_index  output  IDX_WIDTH  position (0..WINDOW-1) of the winning sample within the window.

Function
REQ-012 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-013 The block SHALL implement three states: EMPTY (no sample held), ACCUM (1..WINDOW-1 samples held), DONE (result held, out_valid=1).
REQ-014 EMPTY: in_ready=1; on transfer, load in_data into the running max, index register := 0, count := 1, go to ACCUM (go directly to DONE if WINDOW=1 is ever configured).
REQ-015 ACCUM: in_ready=1; on transfer, if in_data > running max (strict), load in_data and index := count; count := count+1; when the transfer brings count to WINDOW, go to DONE.
REQ-016 DONE: in_ready=0, out_valid=1, out_data/out_index stable; on output transfer, go to EMPTY with count := 0.
REQ-017 Latency SHALL be exactly one cycle: out_valid rises on the edge that accepts the WINDOW-th sample; throughput is WINDOW+1 cycles per window when out_ready is held 1.
REQ-018 The comparison SHALL be synthesizable sign-magnitude ordering of IEEE-754 single: for equal signs, positive compares by magnitude bits [30:0] ascending, negative by [30:0] descending; positive beats negative.
REQ-019 +0 (0x00000000) and -0 (0x80000000) SHALL compare equal; denormals SHALL be ordered by bit pattern like normals.
REQ-020 Inputs with exponent all ones (Inf/NaN) SHALL be ordered by bit pattern under REQ-018 rules with no special NaN handling.
REQ-021 Ties SHALL keep the earlier sample (lowest index), i.e. replacement only on strictly greater.
REQ-022 in_valid while in DONE SHALL have no effect; in_data SHALL be ignored when no transfer occurs.
REQ-023 out_ready while not in DONE SHALL have no effect; out_valid, once asserted, SHALL stay 1 with stable outputs until the output transfer.
REQ-024 The comparison and register update SHALL complete in one cycle (no multicycle path).

Reset
REQ-025 When rst=1 at a rising edge, state := EMPTY, count := 0, running max := 0x00000000, index := 0, out_valid := 0, and in_ready SHALL be 1 in the following cycle.
REQ-026 Reset SHALL take priority over any simultaneous transfer; a partial window or unconsumed result SHALL be discarded.
REQ-027 out_data SHALL read 0x00000000 and out_index 0 after reset until the first window completes.

Verification
REQ-028 WINDOW=4, out_ready=1, inputs 1.0(3F800000), 3.0(40400000), 0.5(3F000000), 2.0(40000000) back-to-back -> out_valid one cycle after 4th accept, out_data=40400000, out_index=1, in_ready=0 for exactly one cycle.
REQ-029 All-negative window -1.0(BF800000), -2.0(C0000000), -0.5(BF000000), -3.0(C0400000) -> out_data=BF000000, out_index=2.
REQ-030 Ties/zero: -0(80000000), +0(00000000), 2.0, 2.0 -> out_data=40000000, out_index=2; separate window +0,-0,-1.0,-2.0 -> out_data=00000000, out_index=0.
REQ-031 Backpressure: complete a window with out_ready=0 for 5 cycles while in_valid=1 -> out_valid stays 1, outputs stable, in_ready=0, no sample lost; next window's first sample accepted the cycle after out_ready=1.
REQ-032 Reset mid-window: accept 2 samples, assert rst one cycle -> out_valid=0, out_data=00000000, next 4 samples form a fresh window with index 0 based on first post-reset sample.
REQ-033 Random: 10,000 random bit-pattern windows with random valid/ready gaps, excluding exponent=FF -> out_data/out_index match a scoreboard using real-valued max with earliest-index tie-break.
